// File: rtl/wb_write_port.sv
// wb_write_port: two-port register-file writeback arbiter with per-port FIFOs.
// Define WB_BYPASS_EN to let a winning request into an empty FIFO skip it.
module wb_fifo #(
  parameter int DW    = 64,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          empty,
  output logic          full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= in_addr;
      data_q[wptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_addr = addr_q[rptr_q];
  assign head_data = data_q[rptr_q];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
endmodule

module wb_write_port #(
  parameter int DW    = 64,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          w_en,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          busy
);
  logic          alu_empty, alu_full, mem_empty, mem_full;
  logic [AW-1:0] alu_head_addr, mem_head_addr;
  logic [DW-1:0] alu_head_data, mem_head_data;
  logic          alu_acc, mem_acc;
  logic          alu_push, mem_push, alu_pop, mem_pop;
  logic          alu_hv, mem_hv, gnt_alu, gnt_mem;
  logic [AW-1:0] alu_src_addr, mem_src_addr, sel_addr;
  logic [DW-1:0] alu_src_data, mem_src_data, sel_data;
  logic          rr_q, rr_d;
  logic          w_en_q, w_en_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  assign alu_ready = ~alu_full;
  assign mem_ready = ~mem_full;
  assign alu_acc   = alu_valid & alu_ready;
  assign mem_acc   = mem_valid & mem_ready;

  always_comb begin
`ifdef WB_BYPASS_EN
    // An incoming request into an empty FIFO competes as if it were the head.
    alu_hv       = ~alu_empty | alu_acc;
    mem_hv       = ~mem_empty | mem_acc;
    alu_src_addr = alu_empty ? alu_addr : alu_head_addr;
    alu_src_data = alu_empty ? alu_data : alu_head_data;
    mem_src_addr = mem_empty ? mem_addr : mem_head_addr;
    mem_src_data = mem_empty ? mem_data : mem_head_data;
`else
    alu_hv       = ~alu_empty;
    mem_hv       = ~mem_empty;
    alu_src_addr = alu_head_addr;
    alu_src_data = alu_head_data;
    mem_src_addr = mem_head_addr;
    mem_src_data = mem_head_data;
`endif
    gnt_alu = alu_hv & (~mem_hv | ~rr_q);
    gnt_mem = ~gnt_alu & mem_hv;
    alu_pop  = gnt_alu & ~alu_empty;
    mem_pop  = gnt_mem & ~mem_empty;
    alu_push = alu_acc & ~(gnt_alu & alu_empty);
    mem_push = mem_acc & ~(gnt_mem & mem_empty);
    rr_d = rr_q;
    if (alu_hv & mem_hv) rr_d = gnt_alu;
    sel_addr = '0;
    sel_data = '0;
    unique case (1'b1)
      gnt_alu: begin
        sel_addr = alu_src_addr;
        sel_data = alu_src_data;
      end
      gnt_mem: begin
        sel_addr = mem_src_addr;
        sel_data = mem_src_data;
      end
      default: ;
    endcase
    // r0 writes are consumed silently and leave the port registers alone.
    w_en_d  = (gnt_alu | gnt_mem) & (sel_addr != '0);
    waddr_d = w_en_d ? sel_addr : waddr_q;
    wdata_d = w_en_d ? sel_data : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q    <= 1'b0;
      w_en_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      rr_q    <= rr_d;
      w_en_q  <= w_en_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_push),
    .pop       (alu_pop),
    .in_addr   (alu_addr),
    .in_data   (alu_data),
    .head_addr (alu_head_addr),
    .head_data (alu_head_data),
    .empty     (alu_empty),
    .full      (alu_full)
  );

  wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_mem_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (mem_push),
    .pop       (mem_pop),
    .in_addr   (mem_addr),
    .in_data   (mem_data),
    .head_addr (mem_head_addr),
    .head_data (mem_head_data),
    .empty     (mem_empty),
    .full      (mem_full)
  );

  assign w_en  = w_en_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = ~alu_empty | ~mem_empty | w_en_q;
endmodule

// File: tb/tb_wb_write_port.sv
// Bench for wb_write_port: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_wb_write_port;
  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] alu_data = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_data = '0;
  logic          w_en;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;

  always #5 clk = ~clk;

  wb_write_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .w_en      (w_en),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    bit            rst_n;
    bit            av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    bit            mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    bit            we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            ar;
    bit            mr;
    bit            bz;
  } vec_t;

  ent_t          qa[$];
  ent_t          qm[$];
  bit            m_rr;
  bit            m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_acc_a;
  bit            m_acc_m;
  int            m_mem_pops;
  int            n_tests = 0;
  int            n_fail = 0;
  vec_t          tbl[$];

  function automatic vec_t mk(
    bit r, bit av, logic [AW-1:0] aa, logic [DW-1:0] ad,
    bit mv, logic [AW-1:0] ma, logic [DW-1:0] md,
    bit we, logic [AW-1:0] wa, logic [DW-1:0] wd,
    bit ar, bit mr, bit bz);
    vec_t v;
    v.rst_n = r;  v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv;    v.ma = ma; v.md = md;
    v.we = we;    v.wa = wa; v.wd = wd;
    v.ar = ar;    v.mr = mr; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: one FIFO queue per port, arbitration by the round-robin rule.
  task automatic model_edge();
    ent_t e;
    bit ha, hm, pa, pm;
    bit byp_a = 1'b0;
    bit byp_m = 1'b0;
    if (!rst_n) begin
      qa.delete();
      qm.delete();
      m_rr = 1'b0; m_wen = 1'b0;
      m_waddr = '0; m_wdata = '0;
      m_acc_a = 1'b0; m_acc_m = 1'b0;
      return;
    end
    m_acc_a = alu_valid && (qa.size() < DEPTH);
    m_acc_m = mem_valid && (qm.size() < DEPTH);
`ifdef WB_BYPASS_EN
    ha = (qa.size() > 0) || m_acc_a;
    hm = (qm.size() > 0) || m_acc_m;
`else
    ha = qa.size() > 0;
    hm = qm.size() > 0;
`endif
    pa = ha && (!hm || !m_rr);
    pm = !pa && hm;
    if (ha && hm) m_rr = pa;
    e = '0;
    if (pa) begin
      if (qa.size() > 0) e = qa.pop_front();
      else begin e = {alu_addr, alu_data}; byp_a = 1'b1; end
    end
    if (pm) begin
      m_mem_pops++;
      if (qm.size() > 0) e = qm.pop_front();
      else begin e = {mem_addr, mem_data}; byp_m = 1'b1; end
    end
    if (m_acc_a && !byp_a) qa.push_back({alu_addr, alu_data});
    if (m_acc_m && !byp_m) qm.push_back({mem_addr, mem_data});
    m_wen = (pa || pm) && (e.addr != '0);
    if (m_wen) begin
      m_waddr = e.addr;
      m_wdata = e.data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("w_en", DW'(w_en), DW'(m_wen));
    chk("waddr", DW'(waddr), DW'(m_waddr));
    chk("wdata", wdata, m_wdata);
    chk("alu_ready", DW'(alu_ready), DW'(qa.size() < DEPTH));
    chk("mem_ready", DW'(mem_ready), DW'(qm.size() < DEPTH));
    chk("busy", DW'(busy), DW'(qa.size() > 0 || qm.size() > 0 || m_wen));
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a,
                                        input logic [AW-1:0] lo,
                                        input logic [AW-1:0] hi);
    return (a >= hi || a < lo) ? lo : a + 1'b1;
  endfunction

  initial begin
    int wr_cnt;
    int acc_cnt;
    int mem_acc;
    bit fell;

    tbl.push_back(mk(0, 0,5'd0,64'h0, 0,5'd0,64'h0, 0,5'd0,64'h0, 1,1,0));
    tbl.push_back(mk(1, 1,5'd3,64'hDEADBEEF, 0,5'd0,64'h0,
                     0,5'd0,64'h0, 1,1,1));
    tbl.push_back(mk(1, 0,5'd0,64'h0, 0,5'd0,64'h0,
                     1,5'd3,64'hDEADBEEF, 1,1,1));
    tbl.push_back(mk(1, 0,5'd0,64'h0, 0,5'd0,64'h0,
                     0,5'd3,64'hDEADBEEF, 1,1,0));
    tbl.push_back(mk(1, 1,5'd0,64'h55, 0,5'd0,64'h0,
                     0,5'd3,64'hDEADBEEF, 1,1,1));
    tbl.push_back(mk(1, 0,5'd0,64'h0, 0,5'd0,64'h0,
                     0,5'd3,64'hDEADBEEF, 1,1,0));
    tbl.push_back(mk(1, 0,5'd0,64'h0, 0,5'd0,64'h0,
                     0,5'd3,64'hDEADBEEF, 1,1,0));
    tbl.push_back(mk(0, 0,5'd0,64'h0, 0,5'd0,64'h0, 0,5'd0,64'h0, 1,1,0));
    tbl.push_back(mk(1, 1,5'd1,64'h101, 1,5'd9,64'h209,
                     0,5'd0,64'h0, 1,1,1));
    tbl.push_back(mk(1, 1,5'd2,64'h102, 1,5'd10,64'h20A,
                     1,5'd1,64'h101, 1,0,1));
    tbl.push_back(mk(1, 1,5'd3,64'h103, 1,5'd11,64'h20B,
                     1,5'd9,64'h209, 0,1,1));
    tbl.push_back(mk(1, 0,5'd0,64'h0, 1,5'd11,64'h20B,
                     1,5'd2,64'h102, 1,0,1));
    tbl.push_back(mk(1, 0,5'd0,64'h0, 0,5'd0,64'h0,
                     1,5'd10,64'h20A, 1,1,1));
    tbl.push_back(mk(1, 0,5'd0,64'h0, 0,5'd0,64'h0,
                     1,5'd3,64'h103, 1,1,1));
    tbl.push_back(mk(1, 0,5'd0,64'h0, 0,5'd0,64'h0,
                     1,5'd11,64'h20B, 1,1,1));
    tbl.push_back(mk(1, 0,5'd0,64'h0, 0,5'd0,64'h0,
                     0,5'd11,64'h20B, 1,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n     = tbl[i].rst_n;
      alu_valid = tbl[i].av;
      alu_addr  = tbl[i].aa;
      alu_data  = tbl[i].ad;
      mem_valid = tbl[i].mv;
      mem_addr  = tbl[i].ma;
      mem_data  = tbl[i].md;
      step();
`ifndef WB_BYPASS_EN
      chk($sformatf("tbl%0d.w_en", i), DW'(w_en), DW'(tbl[i].we));
      chk($sformatf("tbl%0d.waddr", i), DW'(waddr), DW'(tbl[i].wa));
      chk($sformatf("tbl%0d.wdata", i), wdata, tbl[i].wd);
      chk($sformatf("tbl%0d.alu_rdy", i), DW'(alu_ready), DW'(tbl[i].ar));
      chk($sformatf("tbl%0d.mem_rdy", i), DW'(mem_ready), DW'(tbl[i].mr));
      chk($sformatf("tbl%0d.busy", i), DW'(busy), DW'(tbl[i].bz));
`endif
    end

    // Sustained traffic on both ports: mem backs up, nothing lost.
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd1;  alu_data = 64'hA000;
    mem_valid = 1'b1; mem_addr = 5'd16; mem_data = 64'hB000;
    m_mem_pops = 0;
    mem_acc = 0;
    acc_cnt = 0;
    wr_cnt = 0;
    fell = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (w_en) wr_cnt++;
      if (m_acc_a) begin
        acc_cnt++;
        alu_addr = nxt(alu_addr, 5'd1, 5'd15);
        alu_data = alu_data + 64'd1;
      end
      if (m_acc_m) begin
        acc_cnt++;
        mem_acc++;
        mem_addr = nxt(mem_addr, 5'd16, 5'd31);
        mem_data = mem_data + 64'd1;
      end
      if (!fell && !mem_ready) begin
        fell = 1'b1;
        chk("mem_fill_accepts", DW'(mem_acc), DW'(DEPTH + m_mem_pops));
      end
    end
    chk("mem_ready_fell", DW'(fell), DW'(1));
    idle();
    for (int c = 0; c < 8; c++) begin
      step();
      if (w_en) wr_cnt++;
    end
    chk("no_loss_or_dup", DW'(wr_cnt), DW'(acc_cnt));

    // Reset with both FIFOs loaded discards everything.
    alu_valid = 1'b1; mem_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (m_acc_a) alu_addr = nxt(alu_addr, 5'd1, 5'd15);
      if (m_acc_m) mem_addr = nxt(mem_addr, 5'd16, 5'd31);
    end
    chk("pre_reset_busy", DW'(busy), DW'(1));
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_w_en", DW'(w_en), DW'(0));
    chk("rst_alu_ready", DW'(alu_ready), DW'(1));
    chk("rst_mem_ready", DW'(mem_ready), DW'(1));
    chk("rst_busy", DW'(busy), DW'(0));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_no_write", DW'(w_en), DW'(0));
    end

    // Random traffic; producers hold requests until accepted.
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      step();
      if (!(alu_valid && !m_acc_a)) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_addr  = AW'($urandom_range(0, 31));
        alu_data  = {$urandom, $urandom};
      end
      if (!(mem_valid && !m_acc_m)) begin
        mem_valid = ($urandom_range(0, 99) < 60);
        mem_addr  = AW'($urandom_range(0, 31));
        mem_data  = {$urandom, $urandom};
      end
    end
    rst_n = 1'b1;
    idle();
    for (int c = 0; c < 10; c++) step();
    chk("drain_busy", DW'(busy), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
